zxuno_regbus_ctrl: RTL and testbench

ZXUNO_REGBUS_CTRL -- requirements
Module: zxuno_regbus_ctrl

---
 rtl/zxuno_regbus_ctrl.sv | 121 ++++++++++++
 tb/tb_zxuno_regbus_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/zxuno_regbus_ctrl.sv
// ZX-Uno style indirect register bus: an address port selects a register and a data port accesses it.
// Read data comes from the lowest-index enabled slave, and a sticky flag records slave contention.
module zxuno_regbus_ctrl #(
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B,
  parameter int          NSLV      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       a,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              oe_n,
  output logic [7:0]        zxuno_addr,
  output logic              zxuno_regrd,
  output logic              zxuno_regwr,
  output logic              regaddr_changed,
  input  logic [8*NSLV-1:0] slv_dout,
  input  logic [NSLV-1:0]   slv_oe_n,
  output logic              contention
);

  typedef enum logic [1:0] {IDLE, WR_ADDR, WR_DATA, RD} state_t;

  state_t     state_q;
  logic [7:0] addr_q, cap_q;
  logic       regwr_q, chg_q, cont_q, armed_q;

  logic       rdcyc, wrcyc, hit_addr, hit_data;
  logic       wr_addr_c, wr_data_c, rd_c, cont_set;
  logic [7:0] slv_sel;
  logic [3:0] n_low;

  assign rdcyc     = !iorq_n && !rd_n;
  assign wrcyc     = !iorq_n && !wr_n;
  assign hit_addr  = (a == ADDR_PORT);
  assign hit_data  = (a == DATA_PORT);
  assign wr_addr_c = wrcyc && hit_addr;
  assign wr_data_c = wrcyc && hit_data;
  assign rd_c      = rdcyc && (hit_addr || hit_data);

  // Walk from the top down so the lowest enabled index is the one left standing.
  always_comb begin
    slv_sel = 8'hFF;
    n_low   = 4'd0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (!slv_oe_n[k]) begin
        slv_sel = slv_dout[8*k +: 8];
        n_low   = n_low + 4'd1;
      end
    end
  end

  assign zxuno_regrd = rdcyc && hit_data;
  assign oe_n        = !rd_c;
  assign dout        = oe_n ? 8'hFF : (hit_addr ? addr_q : slv_sel);
  assign cont_set    = zxuno_regrd && (n_low >= 4'd2);

  // armed_q blocks a strobe that straddled reset from starting a fresh cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 8'h00;
      cap_q   <= 8'h00;
      regwr_q <= 1'b0;
      chg_q   <= 1'b0;
      cont_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      regwr_q <= 1'b0;
      chg_q   <= 1'b0;
      if (cont_set) cont_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (!armed_q) begin
            if (!wrcyc && !rdcyc) armed_q <= 1'b1;
          end else if (wr_addr_c) begin
            state_q <= WR_ADDR;
            cap_q   <= din;
          end else if (wr_data_c) begin
            state_q <= WR_DATA;
            cap_q   <= din;
          end else if (rd_c) begin
            state_q <= RD;
          end
        end
        WR_ADDR: begin
          if (wr_addr_c) begin
            cap_q <= din;
          end else begin
            state_q <= IDLE;
            addr_q  <= cap_q;
            chg_q   <= 1'b1;
            if (!cont_set) cont_q <= 1'b0;
          end
        end
        WR_DATA: begin
          if (wr_data_c) begin
            cap_q <= din;
          end else begin
            state_q <= IDLE;
            regwr_q <= 1'b1;
          end
        end
        RD: begin
          if (!rd_c) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign zxuno_addr      = addr_q;
  assign zxuno_regwr     = regwr_q;
  assign regaddr_changed = chg_q;
  assign contention      = cont_q;

endmodule

// File: tb/tb_zxuno_regbus_ctrl.sv
// Directed bench for zxuno_regbus_ctrl: expected values are queued as stimulus is driven and popped when observed.
module tb_zxuno_regbus_ctrl;

  localparam logic [15:0] ADDR_PORT = 16'hFC3B;
  localparam logic [15:0] DATA_PORT = 16'hFD3B;
  localparam int          NSLV      = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       a;
  logic              iorq_n, rd_n, wr_n;
  logic [7:0]        din, dout, zxuno_addr;
  logic              oe_n, zxuno_regrd, zxuno_regwr, regaddr_changed, contention;
  logic [8*NSLV-1:0] slv_dout;
  logic [NSLV-1:0]   slv_oe_n;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  zxuno_regbus_ctrl #(.ADDR_PORT(ADDR_PORT), .DATA_PORT(DATA_PORT), .NSLV(NSLV)) dut (
    .clk(clk), .rst(rst), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .din(din), .dout(dout), .oe_n(oe_n), .zxuno_addr(zxuno_addr),
    .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .regaddr_changed(regaddr_changed), .slv_dout(slv_dout),
    .slv_oe_n(slv_oe_n), .contention(contention)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic bus_idle();
    a = 16'h0000; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; din = 8'h00;
  endtask

  task automatic drive_wr(input logic [15:0] adr, input logic [7:0] d);
    a = adr; din = d; iorq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1;
  endtask

  task automatic drive_rd(input logic [15:0] adr);
    a = adr; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
  endtask

  initial begin
    bus_idle();
    rst      = 1'b1;
    slv_oe_n = '1;
    slv_dout = {8'h99, 8'h31, 8'h77, 8'h54};
    tick(3);
    expect_val("rst_addr", 8'h00);  chk(zxuno_addr);
    expect_val("rst_regwr", 8'h00); chk({7'b0, zxuno_regwr});
    expect_val("rst_chg", 8'h00);   chk({7'b0, regaddr_changed});
    expect_val("rst_cont", 8'h00);  chk({7'b0, contention});
    expect_val("rst_oe_n", 8'h01);  chk({7'b0, oe_n});
    expect_val("rst_dout", 8'hFF);  chk(dout);
    rst = 1'b0;
    tick(2);

    // Address write held for three clocks.
    drive_wr(ADDR_PORT, 8'hFF);
    tick(3);
    bus_idle(); #1;
    expect_val("aw_pre_addr", 8'h00); chk(zxuno_addr);
    expect_val("aw_pre_chg", 8'h00);  chk({7'b0, regaddr_changed});
    tick(1);
    expect_val("aw_addr", 8'hFF);     chk(zxuno_addr);
    expect_val("aw_chg_hi", 8'h01);   chk({7'b0, regaddr_changed});
    tick(1);
    expect_val("aw_chg_lo", 8'h00);   chk({7'b0, regaddr_changed});
    expect_val("aw_addr_hold", 8'hFF); chk(zxuno_addr);

    // Foreign port write.
    drive_wr(16'h00FE, 8'h12); #1;
    expect_val("fe_oe_n", 8'h01);     chk({7'b0, oe_n});
    tick(2);
    expect_val("fe_regwr", 8'h00);    chk({7'b0, zxuno_regwr});
    bus_idle();
    tick(1);
    expect_val("fe_chg", 8'h00);      chk({7'b0, regaddr_changed});
    expect_val("fe_regwr2", 8'h00);   chk({7'b0, zxuno_regwr});
    expect_val("fe_addr", 8'hFF);     chk(zxuno_addr);

    // Data write.
    drive_wr(DATA_PORT, 8'hA5);
    tick(2);
    bus_idle(); #1;
    expect_val("dw_pre_regwr", 8'h00); chk({7'b0, zxuno_regwr});
    tick(1);
    expect_val("dw_regwr_hi", 8'h01); chk({7'b0, zxuno_regwr});
    expect_val("dw_addr", 8'hFF);     chk(zxuno_addr);
    expect_val("dw_chg", 8'h00);      chk({7'b0, regaddr_changed});
    tick(1);
    expect_val("dw_regwr_lo", 8'h00); chk({7'b0, zxuno_regwr});

    // Address readback and empty data read.
    drive_wr(ADDR_PORT, 8'h0B);
    tick(1);
    bus_idle();
    tick(1);
    expect_val("aw2_addr", 8'h0B);    chk(zxuno_addr);
    tick(1);
    drive_rd(ADDR_PORT); #1;
    expect_val("ra_oe_n", 8'h00);     chk({7'b0, oe_n});
    expect_val("ra_dout", 8'h0B);     chk(dout);
    expect_val("ra_regrd", 8'h00);    chk({7'b0, zxuno_regrd});
    tick(1);
    bus_idle();
    tick(1);
    drive_rd(DATA_PORT); #1;
    expect_val("rd_none_dout", 8'hFF); chk(dout);
    expect_val("rd_none_oe_n", 8'h00); chk({7'b0, oe_n});
    expect_val("rd_none_regrd", 8'h01); chk({7'b0, zxuno_regrd});
    tick(1);
    expect_val("rd_none_cont", 8'h00); chk({7'b0, contention});
    bus_idle();
    tick(1);
    expect_val("idle_oe_n", 8'h01);   chk({7'b0, oe_n});
    expect_val("idle_dout", 8'hFF);   chk(dout);

    // Two slaves enabled: lowest index wins, contention sticks until the next address write.
    slv_oe_n = 4'b1010;
    drive_rd(DATA_PORT); #1;
    expect_val("ct_dout", 8'h54);     chk(dout);
    expect_val("ct_oe_n", 8'h00);     chk({7'b0, oe_n});
    expect_val("ct_regrd", 8'h01);    chk({7'b0, zxuno_regrd});
    tick(1);
    expect_val("ct_set", 8'h01);      chk({7'b0, contention});
    bus_idle();
    slv_oe_n = '1;
    tick(2);
    expect_val("ct_sticky", 8'h01);   chk({7'b0, contention});
    drive_wr(ADDR_PORT, 8'h0B);
    tick(1);
    bus_idle(); #1;
    expect_val("ct_pre_clr", 8'h01);  chk({7'b0, contention});
    tick(1);
    expect_val("ct_clr", 8'h00);      chk({7'b0, contention});
    expect_val("ct_clr_chg", 8'h01);  chk({7'b0, regaddr_changed});
    slv_oe_n = 4'b0111;
    drive_rd(DATA_PORT); #1;
    expect_val("one_dout", 8'h99);    chk(dout);
    tick(1);
    expect_val("one_cont", 8'h00);    chk({7'b0, contention});
    bus_idle();
    slv_oe_n = '1;
    tick(1);

    // Reset in the middle of an address write.
    drive_wr(ADDR_PORT, 8'h3C);
    tick(2);
    rst = 1'b1; #1;
    expect_val("mr_addr_rst", 8'h00); chk(zxuno_addr);
    tick(1);
    rst = 1'b0;
    tick(2);
    expect_val("mr_chg_strobe", 8'h00); chk({7'b0, regaddr_changed});
    bus_idle();
    tick(1);
    expect_val("mr_addr", 8'h00);     chk(zxuno_addr);
    expect_val("mr_chg", 8'h00);      chk({7'b0, regaddr_changed});
    tick(1);
    expect_val("mr_chg2", 8'h00);     chk({7'b0, regaddr_changed});
    expect_val("mr_addr2", 8'h00);    chk(zxuno_addr);
    drive_wr(ADDR_PORT, 8'h3C);
    tick(2);
    bus_idle();
    tick(1);
    expect_val("mr_new_addr", 8'h3C); chk(zxuno_addr);
    expect_val("mr_new_chg", 8'h01);  chk({7'b0, regaddr_changed});
    tick(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
